// File: rtl/decoder_pkg.sv
// Shared types and helpers for the registered one-hot decoder / channel scanner.
// The DECODER_SCAN_BLANK_EN build option lives in decoder_scan_n.sv.
package decoder_pkg;

   typedef enum logic {
      MANUAL = 1'b0,
      SCAN   = 1'b1
   } scan_state_t;

   // Widest decoder the shared helper supports; instances slice it down to N.
   localparam int unsigned ONEHOT_MAX_N = 256;

   // Bounded one-hot encode: out-of-range indices decode to all-zero.
   function automatic logic [ONEHOT_MAX_N-1:0] onehot_n(input int unsigned idx,
                                                        input int unsigned n);
      logic [ONEHOT_MAX_N-1:0] v;
      v = '0;
      if ((idx < n) && (idx < ONEHOT_MAX_N)) begin
         v = ONEHOT_MAX_N'(1) << idx;
      end
      return v;
   endfunction

endpackage

// File: rtl/decoder_scan_n_if.sv
// Select/scan bus between a controller (master) and decoder_scan_n (slave).
interface decoder_scan_n_if #(
   parameter int N = 8,
   parameter int M = $clog2(N)
);

   logic         EN;
   logic         MODE;
   logic [M-1:0] SEL;
   logic [N-1:0] Y;
   logic [M-1:0] IDX;
   logic         WRAP;

   modport master (
      output EN, MODE, SEL,
      input  Y, IDX, WRAP
   );

   modport slave (
      input  EN, MODE, SEL,
      output Y, IDX, WRAP
   );

endinterface

// File: rtl/decoder_scan_n_dwell_counter.sv
// Modulo-DWELL counter for the scanner: counts while enabled, flags the
// last cycle of a channel's dwell, and can be cleared synchronously.
module dwell_counter #(
   parameter int DWELL = 4,
   parameter int DW    = $clog2(DWELL + 1)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic tc
);

   localparam logic [DW-1:0] CNT_LAST = DW'(DWELL - 1);

   logic [DW-1:0] cnt_q, cnt_d;

   assign tc = (cnt_q == CNT_LAST);

   // NOTE: cnt_d is given its hold value first so no path leaves it unassigned (no latch).
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = tc ? '0 : cnt_q + 1'b1;
      end
   end

   // NOTE: state is updated with <= so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/decoder_scan_n.sv
// Registered one-hot decoder with an auto-scan mode stepping through N channels.
// Define DECODER_SCAN_BLANK_EN to insert a one-cycle all-zero blank on each scan advance.
module decoder_scan_n
   import decoder_pkg::*;
#(
   parameter int N     = 8,
   parameter int M     = $clog2(N),
   parameter int DWELL = 4,
   parameter int DW    = $clog2(DWELL + 1)
) (
   input  logic            CLK,
   input  logic            N_RESET,
   decoder_scan_n_if.slave bus
);

   localparam logic         ST_MANUAL = MANUAL;
   localparam logic         ST_SCAN   = SCAN;
   localparam logic [M-1:0] IDX_LAST  = M'(N - 1);

`ifdef DECODER_SCAN_BLANK_EN
   localparam logic BLANK_EN = 1'b1;
`else
   localparam logic BLANK_EN = 1'b0;
`endif

   logic         state_q, state_d;
   logic [N-1:0] y_q, y_d;
   logic [M-1:0] idx_q, idx_d;
   logic         wrap_q, wrap_d;
   logic         blank_q, blank_d;

   logic         cnt_en, cnt_clr, cnt_tc;
   logic [M-1:0] idx_next;
   logic         sel_ok;

   function automatic logic [N-1:0] decode(input logic [M-1:0] i);
      return N'(onehot_n(32'(i), 32'(N)));
   endfunction

   dwell_counter #(
      .DWELL (DWELL),
      .DW    (DW)
   ) u_dwell (
      .clk   (CLK),
      .rst_n (N_RESET),
      .en    (cnt_en),
      .clr   (cnt_clr),
      .tc    (cnt_tc)
   );

   assign idx_next = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
   assign sel_ok   = (int'(bus.SEL) < N);

   always_comb begin
      state_d = state_q;
      y_d     = y_q;
      idx_d   = idx_q;
      wrap_d  = 1'b0;
      blank_d = blank_q;
      cnt_en  = 1'b0;
      cnt_clr = 1'b0;

      if (bus.EN) begin
         if (state_q == ST_MANUAL && bus.MODE) begin
            // Scan starts on SEL, falling back to channel 0 when SEL is out of range.
            state_d = ST_SCAN;
            idx_d   = sel_ok ? bus.SEL : '0;
            y_d     = decode(sel_ok ? bus.SEL : '0);
            blank_d = 1'b0;
            cnt_clr = 1'b1;
         end else if (!bus.MODE) begin
            state_d = ST_MANUAL;
            idx_d   = bus.SEL;
            y_d     = decode(bus.SEL);
            blank_d = 1'b0;
            cnt_clr = 1'b1;
         end else if (blank_q) begin
            // Blank cycle does not consume dwell time; light the new channel now.
            blank_d = 1'b0;
            y_d     = decode(idx_q);
         end else begin
            cnt_en = 1'b1;
            if (cnt_tc) begin
               idx_d   = idx_next;
               wrap_d  = (idx_q == IDX_LAST);
               blank_d = BLANK_EN;
               y_d     = BLANK_EN ? '0 : decode(idx_next);
            end
         end
      end
   end

   always_ff @(posedge CLK or negedge N_RESET) begin
      if (!N_RESET) begin
         state_q <= ST_MANUAL;
         y_q     <= '0;
         idx_q   <= '0;
         wrap_q  <= 1'b0;
         blank_q <= 1'b0;
      end else begin
         state_q <= state_d;
         y_q     <= y_d;
         idx_q   <= idx_d;
         wrap_q  <= wrap_d;
         blank_q <= blank_d;
      end
   end

   assign bus.Y    = y_q;
   assign bus.IDX  = idx_q;
   assign bus.WRAP = wrap_q;

   a_y_onehot0 : assert property (@(posedge CLK) disable iff (!N_RESET) $onehot0(y_q));
   a_idx_range : assert property (@(posedge CLK) disable iff (!N_RESET)
                                  (state_q == ST_SCAN) |-> (int'(idx_q) < N));

endmodule

// File: tb/tb_decoder_scan_n.sv
// Randomised bench for decoder_scan_n: an N=8/DWELL=4 and an N=6/DWELL=1 instance
// share one stimulus stream and are checked each cycle against a slot-based model.
module tb_decoder_scan_n;

`ifdef DECODER_SCAN_BLANK_EN
   localparam int BLANK = 1;
`else
   localparam int BLANK = 0;
`endif

   logic       clk;
   logic       rst_n;
   logic       en;
   logic       mode;
   logic [2:0] sel;

   int n_vec;
   int n_bad;

   decoder_scan_n_if #(.N(8)) bus8 ();
   decoder_scan_n_if #(.N(6)) bus6 ();

   assign bus8.EN   = en;
   assign bus8.MODE = mode;
   assign bus8.SEL  = sel;
   assign bus6.EN   = en;
   assign bus6.MODE = mode;
   assign bus6.SEL  = sel;

   decoder_scan_n #(.N(8), .DWELL(4)) u_dut8 (
      .CLK     (clk),
      .N_RESET (rst_n),
      .bus     (bus8)
   );

   decoder_scan_n #(.N(6), .DWELL(1)) u_dut6 (
      .CLK     (clk),
      .N_RESET (rst_n),
      .bus     (bus6)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: per instance, whether scanning, the current channel, and
   // the age of the current slot (blank cycle, if any, then DWELL visible cycles).
   int m_n[2]   = '{8, 6};
   int m_d[2]   = '{4, 1};
   bit m_scan[2];
   int m_idx[2];
   int m_age[2];
   int m_y[2];
   bit m_wrap[2];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_scan[k] = 1'b0;
         m_idx[k]  = 0;
         m_age[k]  = 0;
         m_y[k]    = 0;
         m_wrap[k] = 1'b0;
      end
   endtask

   task automatic model_manual(input int k, input int s);
      m_scan[k] = 1'b0;
      m_idx[k]  = s;
      m_y[k]    = (s < m_n[k]) ? (1 << s) : 0;
   endtask

   task automatic model_step(input int k, input bit e, input bit md, input int s);
      m_wrap[k] = 1'b0;
      if (!e) return;
      if (!md) begin
         model_manual(k, s);
      end else if (!m_scan[k]) begin
         m_scan[k] = 1'b1;
         m_idx[k]  = (s < m_n[k]) ? s : 0;
         m_age[k]  = BLANK;
         m_y[k]    = 1 << m_idx[k];
      end else begin
         m_age[k]++;
         if (m_age[k] == m_d[k] + BLANK) begin
            m_age[k]  = 0;
            m_idx[k]  = (m_idx[k] + 1) % m_n[k];
            m_wrap[k] = (m_idx[k] == 0);
         end
         m_y[k] = (BLANK != 0 && m_age[k] == 0) ? 0 : (1 << m_idx[k]);
      end
   endtask

   task automatic compare_all();
      check("y8",    32'(bus8.Y),    32'(m_y[0]));
      check("idx8",  32'(bus8.IDX),  32'(m_idx[0]));
      check("wrap8", 32'(bus8.WRAP), 32'(m_wrap[0]));
      check("y6",    32'(bus6.Y),    32'(m_y[1]));
      check("idx6",  32'(bus6.IDX),  32'(m_idx[1]));
      check("wrap6", 32'(bus6.WRAP), 32'(m_wrap[1]));
   endtask

   task automatic cycle(input bit e, input bit md, input int s);
      en   = e;
      mode = md;
      sel  = 3'(s);
      @(posedge clk);
      for (int k = 0; k < 2; k++) model_step(k, e, md, s);
      #1;
      compare_all();
   endtask

   initial begin
      bit rmode;

      n_vec = 0;
      n_bad = 0;
      rst_n = 1'b0;
      en    = 1'b0;
      mode  = 1'b0;
      sel   = '0;
      model_reset();
      #12;
      compare_all();
      rst_n = 1'b1;

      // Manual decode, including out-of-range selects on the 6-channel instance.
      cycle(1, 0, 3);
      cycle(1, 0, 7);
      cycle(1, 0, 6);

      // Scan entry with out-of-range SEL, then a long scan starting at channel 6.
      cycle(1, 1, 7);
      for (int i = 0; i < 10; i++) cycle(1, 1, $urandom_range(0, 7));
      cycle(1, 0, 6);
      cycle(1, 1, 6);
      for (int i = 0; i < 70; i++) cycle(1, 1, 0);

      // Freeze mid-dwell, then resume.
      for (int i = 0; i < 10; i++) cycle(0, 1, $urandom_range(0, 7));
      for (int i = 0; i < 6; i++) cycle(1, 1, 0);

      // Asynchronous reset mid-scan, checked before the next clock edge.
      cycle(1, 0, 5);
      cycle(1, 1, 5);
      cycle(1, 1, 5);
      #3;
      rst_n = 1'b0;
      #1;
      model_reset();
      compare_all();
      #2;
      rst_n = 1'b1;

      // Random traffic: long mode runs, sporadic enable drops, random selects.
      rmode = 1'b1;
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 39) == 0) rmode = ~rmode;
         cycle(($urandom_range(0, 7) != 0), rmode, $urandom_range(0, 7));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
